// File: rtl/snax_gemm_tile_ctrl_if.sv
// ---------------------------------------------------------------------------
// snax_gemm_tile_ctrl_if : job, tile-request and status bus of the tile ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface snax_gemm_tile_ctrl_if #(
  parameter int unsigned DimWidth  = 8,
  parameter int unsigned AddrWidth = 32
);
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic [DimWidth-1:0]  cfg_m_i;
  logic [DimWidth-1:0]  cfg_k_i;
  logic [DimWidth-1:0]  cfg_n_i;
  logic [AddrWidth-1:0] cfg_base_a_i;
  logic [AddrWidth-1:0] cfg_base_b_i;
  logic [AddrWidth-1:0] cfg_base_c_i;

  logic                 rd_valid_o;
  logic                 rd_ready_i;
  logic [AddrWidth-1:0] rd_addr_a_o;
  logic [AddrWidth-1:0] rd_addr_b_o;
  logic                 rd_first_k_o;
  logic                 rd_last_k_o;

  logic                 res_valid_i;

  logic                 wr_valid_o;
  logic                 wr_ready_i;
  logic [AddrWidth-1:0] wr_addr_c_o;

  logic                 busy_o;
  logic                 done_o;

  // master = the controller, slave = CSR front-end / streamer / core side
  modport master (
    input  cfg_valid_i, cfg_m_i, cfg_k_i, cfg_n_i,
           cfg_base_a_i, cfg_base_b_i, cfg_base_c_i,
           rd_ready_i, res_valid_i, wr_ready_i,
    output cfg_ready_o, rd_valid_o, rd_addr_a_o, rd_addr_b_o,
           rd_first_k_o, rd_last_k_o, wr_valid_o, wr_addr_c_o,
           busy_o, done_o
  );

  modport slave (
    output cfg_valid_i, cfg_m_i, cfg_k_i, cfg_n_i,
           cfg_base_a_i, cfg_base_b_i, cfg_base_c_i,
           rd_ready_i, res_valid_i, wr_ready_i,
    input  cfg_ready_o, rd_valid_o, rd_addr_a_o, rd_addr_b_o,
           rd_first_k_o, rd_last_k_o, wr_valid_o, wr_addr_c_o,
           busy_o, done_o
  );
endinterface

`default_nettype wire

// File: rtl/snax_gemm_tile_ctrl.sv
// ---------------------------------------------------------------------------
// snax_gemm_tile_ctrl : m->n->k tile-loop sequencer for the SNAX GEMM core
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snax_gemm_tile_ctrl #(
  parameter int unsigned DimWidth   = 8,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned TileBytesA = 64,
  parameter int unsigned TileBytesB = 64,
  parameter int unsigned TileBytesC = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  snax_gemm_tile_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WAIT_RES = 3'd2,
    S_WR       = 3'd3,
    S_FIN      = 3'd4
  } state_e;

  localparam logic [AddrWidth-1:0] c_step_a = AddrWidth'(TileBytesA);
  localparam logic [AddrWidth-1:0] c_step_b = AddrWidth'(TileBytesB);
  localparam logic [AddrWidth-1:0] c_step_c = AddrWidth'(TileBytesC);

  state_e               state_q, state_d;
  logic [DimWidth-1:0]  dim_m_q, dim_m_d;
  logic [DimWidth-1:0]  dim_k_q, dim_k_d;
  logic [DimWidth-1:0]  dim_n_q, dim_n_d;
  logic [DimWidth-1:0]  m_q, m_d;
  logic [DimWidth-1:0]  n_q, n_d;
  logic [DimWidth-1:0]  k_q, k_d;
  logic [AddrWidth-1:0] ptr_a_q, ptr_a_d;
  logic [AddrWidth-1:0] row_a_q, row_a_d;
  logic [AddrWidth-1:0] ptr_b_q, ptr_b_d;
  logic [AddrWidth-1:0] base_b_q, base_b_d;
  logic [AddrWidth-1:0] ptr_c_q, ptr_c_d;
  logic                 res_pend_q, res_pend_d;

  logic w_k_last;
  logic w_n_last;
  logic w_m_last;
  logic w_dim_zero;
  logic w_in_rd;
  logic w_in_wr;

  assign w_k_last   = (k_q == dim_k_q - DimWidth'(1));
  assign w_n_last   = (n_q == dim_n_q - DimWidth'(1));
  assign w_m_last   = (m_q == dim_m_q - DimWidth'(1));
  assign w_dim_zero = (bus.cfg_m_i == '0) || (bus.cfg_k_i == '0) || (bus.cfg_n_i == '0);
  assign w_in_rd    = (state_q == S_RD);
  assign w_in_wr    = (state_q == S_WR);

  // Pointers advance by one tile per handshake. At the end of a k sweep
  // ptr_a already sits on the next A row and ptr_b on the next B column,
  // so the n/m steps only need to rewind, never multiply.
  always_comb begin
    state_d    = state_q;
    dim_m_d    = dim_m_q;
    dim_k_d    = dim_k_q;
    dim_n_d    = dim_n_q;
    m_d        = m_q;
    n_d        = n_q;
    k_d        = k_q;
    ptr_a_d    = ptr_a_q;
    row_a_d    = row_a_q;
    ptr_b_d    = ptr_b_q;
    base_b_d   = base_b_q;
    ptr_c_d    = ptr_c_q;
    res_pend_d = res_pend_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_valid_i) begin
          dim_m_d    = bus.cfg_m_i;
          dim_k_d    = bus.cfg_k_i;
          dim_n_d    = bus.cfg_n_i;
          m_d        = '0;
          n_d        = '0;
          k_d        = '0;
          ptr_a_d    = bus.cfg_base_a_i;
          row_a_d    = bus.cfg_base_a_i;
          ptr_b_d    = bus.cfg_base_b_i;
          base_b_d   = bus.cfg_base_b_i;
          ptr_c_d    = bus.cfg_base_c_i;
          res_pend_d = 1'b0;
          state_d    = w_dim_zero ? S_FIN : S_RD;
        end
      end

      S_RD: begin
        if (bus.res_valid_i) begin
          res_pend_d = 1'b1;
        end
        if (bus.rd_ready_i) begin
          ptr_a_d = ptr_a_q + c_step_a;
          ptr_b_d = ptr_b_q + c_step_b;
          if (w_k_last) begin
            k_d     = '0;
            state_d = S_WAIT_RES;
          end else begin
            k_d = k_q + DimWidth'(1);
          end
        end
      end

      S_WAIT_RES: begin
        if (res_pend_q || bus.res_valid_i) begin
          res_pend_d = 1'b0;
          state_d    = S_WR;
        end
      end

      S_WR: begin
        if (bus.wr_ready_i) begin
          ptr_c_d = ptr_c_q + c_step_c;
          if (!w_n_last) begin
            n_d     = n_q + DimWidth'(1);
            ptr_a_d = row_a_q;
            state_d = S_RD;
          end else begin
            n_d     = '0;
            ptr_b_d = base_b_q;
            row_a_d = ptr_a_q;
            if (w_m_last) begin
              state_d = S_FIN;
            end else begin
              m_d     = m_q + DimWidth'(1);
              state_d = S_RD;
            end
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      dim_m_q    <= '0;
      dim_k_q    <= '0;
      dim_n_q    <= '0;
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      ptr_a_q    <= '0;
      row_a_q    <= '0;
      ptr_b_q    <= '0;
      base_b_q   <= '0;
      ptr_c_q    <= '0;
      res_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dim_m_q    <= dim_m_d;
      dim_k_q    <= dim_k_d;
      dim_n_q    <= dim_n_d;
      m_q        <= m_d;
      n_q        <= n_d;
      k_q        <= k_d;
      ptr_a_q    <= ptr_a_d;
      row_a_q    <= row_a_d;
      ptr_b_q    <= ptr_b_d;
      base_b_q   <= base_b_d;
      ptr_c_q    <= ptr_c_d;
      res_pend_q <= res_pend_d;
    end
  end

  // Request fields are forced to zero outside their state so idle outputs stay quiet.
  assign bus.cfg_ready_o  = (state_q == S_IDLE);
  assign bus.rd_valid_o   = w_in_rd;
  assign bus.rd_addr_a_o  = w_in_rd ? ptr_a_q : '0;
  assign bus.rd_addr_b_o  = w_in_rd ? ptr_b_q : '0;
  assign bus.rd_first_k_o = w_in_rd && (k_q == '0);
  assign bus.rd_last_k_o  = w_in_rd && w_k_last;
  assign bus.wr_valid_o   = w_in_wr;
  assign bus.wr_addr_c_o  = w_in_wr ? ptr_c_q : '0;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.done_o       = (state_q == S_FIN);

endmodule

`default_nettype wire
